pipeline_hazard_ctrl: RTL and testbench

- Drives the update/flush controls of all four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. It is the control-side counterpart of those latches.
- Resolves instruction-cache wait, data-cache wait, load-use hazards, taken branch/jump redirects resolved in MEM, and halt.
- Keeps saturating stall/flush performance counters.
- One instance per core, sitting beside the datapath.

---
 rtl/pipeline_hazard_ctrl_if.sv | 40 ++++
 rtl/pipeline_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath-facing hazard inputs and pipeline-latch control outputs of pipeline_hazard_ctrl.
// ihit/dhit are completion strobes sampled every cycle; there is no valid/ready backpressure.
interface pipeline_hazard_ctrl_if;
    logic       ihit;
    logic       dhit;
    logic       dmem_req;
    logic       idex_mem_to_reg;
    logic [4:0] idex_rt;
    logic [4:0] ifid_rs;
    logic [4:0] ifid_rt;
    logic       branch_taken;
    logic       jump_taken;
    logic       halt_mem;

    logic       pc_en;
    logic       ifid_update;
    logic       idex_update;
    logic       exmem_update;
    logic       memwb_update;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       memwb_flush;

    // Controller side
    modport slave (
        input  ihit, dhit, dmem_req, idex_mem_to_reg, idex_rt, ifid_rs, ifid_rt,
               branch_taken, jump_taken, halt_mem,
        output pc_en, ifid_update, idex_update, exmem_update, memwb_update,
               ifid_flush, idex_flush, exmem_flush, memwb_flush
    );

    // Datapath side
    modport master (
        output ihit, dhit, dmem_req, idex_mem_to_reg, idex_rt, ifid_rs, ifid_rt,
               branch_taken, jump_taken, halt_mem,
        input  pc_en, ifid_update, idex_update, exmem_update, memwb_update,
               ifid_flush, idex_flush, exmem_flush, memwb_flush
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: drives PC enable and update/flush of the four pipeline latches,
// tracks halt, and keeps saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 nRST,
    pipeline_hazard_ctrl_if.slave bus,
    input  logic                 clr_stats,
    output logic                 halted,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DWAIT  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t state, state_next;
    logic   stall_inc, flush_inc;
    logic   load_use;

    assign load_use = bus.idex_mem_to_reg && (bus.idex_rt != 5'd0) &&
                      ((bus.idex_rt == bus.ifid_rs) || (bus.idex_rt == bus.ifid_rt));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next       = state;
        stall_inc        = 1'b0;
        flush_inc        = 1'b0;
        bus.pc_en        = 1'b0;
        bus.ifid_update  = 1'b0;
        bus.idex_update  = 1'b0;
        bus.exmem_update = 1'b0;
        bus.memwb_update = 1'b0;
        bus.ifid_flush   = 1'b0;
        bus.idex_flush   = 1'b0;
        bus.exmem_flush  = 1'b0;
        bus.memwb_flush  = 1'b0;
        case (state)
            IDLE: state_next = RUN;
            RUN, DWAIT: begin
                // Priority order: memory freeze, halt, redirect, load-use, fetch miss, advance.
                if (bus.dmem_req && !bus.dhit) begin
                    state_next = DWAIT;
                    stall_inc  = 1'b1;
                end else if (bus.halt_mem) begin
                    bus.ifid_flush   = 1'b1;
                    bus.idex_flush   = 1'b1;
                    bus.exmem_flush  = 1'b1;
                    bus.memwb_update = 1'b1;
                    state_next       = HALTED;
                end else if (bus.branch_taken || bus.jump_taken) begin
                    // Redirect squashes the wrong path, including any load-use it contained.
                    bus.ifid_flush   = 1'b1;
                    bus.idex_flush   = 1'b1;
                    bus.exmem_flush  = 1'b1;
                    bus.memwb_update = 1'b1;
                    bus.pc_en        = 1'b1;
                    flush_inc        = 1'b1;
                    stall_inc        = 1'b1;
                    state_next       = RUN;
                end else if (load_use) begin
                    bus.idex_flush   = 1'b1;
                    bus.exmem_update = 1'b1;
                    bus.memwb_update = 1'b1;
                    stall_inc        = 1'b1;
                    state_next       = RUN;
                end else if (!bus.ihit) begin
                    bus.ifid_flush   = 1'b1;
                    bus.idex_update  = 1'b1;
                    bus.exmem_update = 1'b1;
                    bus.memwb_update = 1'b1;
                    stall_inc        = 1'b1;
                    state_next       = RUN;
                end else begin
                    bus.pc_en        = 1'b1;
                    bus.ifid_update  = 1'b1;
                    bus.idex_update  = 1'b1;
                    bus.exmem_update = 1'b1;
                    bus.memwb_update = 1'b1;
                    state_next       = RUN;
                end
            end
            HALTED: state_next = HALTED;
            default: state_next = IDLE;
        endcase
    end

    assign halted    = (state == HALTED);
    assign fsm_state = state;

    // clr_stats wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (clr_stats) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
            if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl with hand-computed control patterns and counter values.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    // {pc_en, ifid_u, idex_u, exmem_u, memwb_u, ifid_f, idex_f, exmem_f, memwb_f}
    localparam logic [8:0] C_ZERO   = 9'b0_0000_0000;
    localparam logic [8:0] C_NORMAL = 9'b1_1111_0000;
    localparam logic [8:0] C_HALT   = 9'b0_0001_1110;
    localparam logic [8:0] C_BRANCH = 9'b1_0001_1110;
    localparam logic [8:0] C_LDUSE  = 9'b0_0011_0100;
    localparam logic [8:0] C_IMISS  = 9'b0_0111_1000;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DWAIT = 2'd2, S_HALTED = 2'd3;

    logic             CLK;
    logic             nRST;
    logic             clr_stats;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       fsm_state;
    logic [8:0]       ctl;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus.slave),
        .clr_stats (clr_stats),
        .halted    (halted),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .fsm_state (fsm_state)
    );

    assign ctl = {bus.pc_en, bus.ifid_update, bus.idex_update, bus.exmem_update, bus.memwb_update,
                  bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        bus.ihit            = 1'b1;
        bus.dhit            = 1'b0;
        bus.dmem_req        = 1'b0;
        bus.idex_mem_to_reg = 1'b0;
        bus.idex_rt         = 5'd0;
        bus.ifid_rs         = 5'd0;
        bus.ifid_rt         = 5'd0;
        bus.branch_taken    = 1'b0;
        bus.jump_taken      = 1'b0;
        bus.halt_mem        = 1'b0;
        clr_stats           = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle_inputs();
        tick();
        tick();
        nRST = 1'b1;
    endtask

    initial begin
        do_reset();

        // IDLE cycle: everything quiet
        mid();
        check("idle_ctl", ctl, C_ZERO);
        check("idle_state", fsm_state, S_IDLE);
        check("idle_halted", halted, 0);
        check("idle_stall", stall_cnt, 0);
        tick();
        mid();
        check("run_normal", ctl, C_NORMAL);
        check("run_state", fsm_state, S_RUN);
        check("run_stall0", stall_cnt, 0);
        tick();

        // Load-use on rs
        bus.idex_mem_to_reg = 1'b1; bus.idex_rt = 5'd5; bus.ifid_rs = 5'd5;
        mid();
        check("lduse_rs_ctl", ctl, C_LDUSE);
        tick();
        check("lduse_rs_stall", stall_cnt, 1);
        // Register 0 never stalls
        bus.idex_rt = 5'd0; bus.ifid_rs = 5'd0;
        mid();
        check("lduse_r0_ctl", ctl, C_NORMAL);
        tick();
        check("lduse_r0_stall", stall_cnt, 1);
        // Load-use on rt
        bus.idex_rt = 5'd7; bus.ifid_rs = 5'd3; bus.ifid_rt = 5'd7;
        mid();
        check("lduse_rt_ctl", ctl, C_LDUSE);
        tick();
        check("lduse_rt_stall", stall_cnt, 2);
        idle_inputs();

        // Fetch miss
        bus.ihit = 1'b0;
        mid();
        check("imiss_ctl", ctl, C_IMISS);
        tick();
        check("imiss_stall", stall_cnt, 3);
        idle_inputs();

        // Clear with no concurrent event
        clr_stats = 1'b1;
        tick();
        check("clr_stall", stall_cnt, 0);
        clr_stats = 1'b0;

        // Data-cache wait: 3 freeze cycles then completion
        bus.dmem_req = 1'b1; bus.dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            check($sformatf("dwait_ctl%0d", i), ctl, C_ZERO);
            tick();
            check($sformatf("dwait_state%0d", i), fsm_state, S_DWAIT);
        end
        bus.dhit = 1'b1;
        mid();
        check("dhit_ctl", ctl, C_NORMAL);
        tick();
        check("dhit_state", fsm_state, S_RUN);
        check("dwait_stall", stall_cnt, 3);
        idle_inputs();

        // Branch beats load-use
        bus.branch_taken = 1'b1;
        bus.idex_mem_to_reg = 1'b1; bus.idex_rt = 5'd5; bus.ifid_rs = 5'd5;
        mid();
        check("br_lduse_ctl", ctl, C_BRANCH);
        tick();
        check("br_flush", flush_cnt, 1);
        check("br_stall", stall_cnt, 4);
        idle_inputs();

        // Freeze beats branch; flush happens on the dhit cycle
        bus.dmem_req = 1'b1; bus.dhit = 1'b0; bus.branch_taken = 1'b1;
        mid();
        check("br_freeze_ctl", ctl, C_ZERO);
        tick();
        check("br_freeze_state", fsm_state, S_DWAIT);
        check("br_freeze_flush", flush_cnt, 1);
        bus.dhit = 1'b1;
        mid();
        check("br_dhit_ctl", ctl, C_BRANCH);
        tick();
        check("br_dhit_flush", flush_cnt, 2);
        check("br_dhit_stall", stall_cnt, 6);
        check("br_dhit_state", fsm_state, S_RUN);
        idle_inputs();

        // Jump
        bus.jump_taken = 1'b1;
        mid();
        check("jmp_ctl", ctl, C_BRANCH);
        tick();
        check("jmp_flush", flush_cnt, 3);
        idle_inputs();

        // Saturation: 2^CNT_W+2 stall cycles from 7 stays at 15
        bus.ihit = 1'b0;
        for (int i = 0; i < (1 << CNT_W) + 2; i++) tick();
        check("sat_stall", stall_cnt, 15);
        check("sat_flush", flush_cnt, 3);
        // clr_stats beats a concurrent stall
        clr_stats = 1'b1;
        mid();
        check("clr_imiss_ctl", ctl, C_IMISS);
        tick();
        check("clr_conc_stall", stall_cnt, 0);
        check("clr_conc_flush", flush_cnt, 0);
        idle_inputs();

        // Make counters nonzero, then halt
        bus.ihit = 1'b0;
        tick();
        bus.ihit = 1'b1; bus.branch_taken = 1'b1;
        tick();
        idle_inputs();
        check("pre_halt_stall", stall_cnt, 2);
        bus.halt_mem = 1'b1;
        mid();
        check("halt_ctl", ctl, C_HALT);
        tick();
        check("halt_state", fsm_state, S_HALTED);
        bus.halt_mem = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.ihit = i[0]; bus.branch_taken = ~i[0];
            mid();
            check($sformatf("halted_ctl%0d", i), ctl, C_ZERO);
            check($sformatf("halted_flag%0d", i), halted, 1);
            tick();
        end
        check("halted_stall_frozen", stall_cnt, 2);
        check("halted_flush_frozen", flush_cnt, 1);

        // Async reset mid-HALTED
        nRST = 1'b0;
        #1;
        check("rst_state", fsm_state, S_IDLE);
        check("rst_halted", halted, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_flush", flush_cnt, 0);
        idle_inputs();
        tick();
        nRST = 1'b1;
        tick();
        // Now RUN; create a stall, halt, then clear stats while halted
        bus.ihit = 1'b0;
        tick();
        bus.ihit = 1'b1; bus.halt_mem = 1'b1;
        tick();
        bus.halt_mem = 1'b0;
        check("halt2_stall", stall_cnt, 1);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("halt2_clr_stall", stall_cnt, 0);
        check("halt2_still_halted", halted, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time guard
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
